// File: rtl/rr_arb_pkg.sv
// Shared types and elaboration-time helpers for the rr_arb_mux block.
package rr_arb_pkg;

  // Arbitration FSM: free arbitration, or locked to one channel mid-burst.
  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Channel index width; never narrower than one bit.
  function automatic int idw_of(input int nch);
    return (clog2(nch) < 1) ? 1 : clog2(nch);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request at or above
// 'start' (wrapping), or lowest set request when fixed_mode is high.
module rr_pick #(
  parameter int NCH = 2,
  parameter int IDW = 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IDW-1:0] start,
  input  logic           fixed_mode,
  output logic [NCH-1:0] grant,
  output logic [IDW-1:0] idx
);

  logic [IDW-1:0]   base_s;
  logic [2*NCH-1:0] req_dbl_s;
  logic [NCH-1:0]   req_rot_s;
  logic [NCH-1:0]   gnt_rot_s;
  logic [2*NCH-1:0] gnt_dbl_s;
  logic             found_s;

  // Rotate requests so 'start' sits at bit 0, pick lowest, rotate grant back.
  always_comb begin
    int pos;
    pos       = 0;
    base_s    = fixed_mode ? {IDW{1'b0}} : start;
    req_dbl_s = {req, req} >> base_s;
    req_rot_s = req_dbl_s[NCH-1:0];
    gnt_rot_s = {NCH{1'b0}};
    found_s   = 1'b0;
    idx       = {IDW{1'b0}};
    for (int k = 0; k < NCH; k++) begin
      if (!found_s && req_rot_s[k]) begin
        found_s      = 1'b1;
        gnt_rot_s[k] = 1'b1;
        pos          = int'(base_s) + k;
        // Explicit wrap so non-power-of-2 channel counts stay in range.
        if (pos >= NCH) begin
          pos = pos - NCH;
        end else begin
          pos = pos;
        end
        idx = IDW'(pos);
      end else begin
        found_s = found_s;
      end
    end
    gnt_dbl_s = {{NCH{1'b0}}, gnt_rot_s} << base_s;
    grant     = gnt_dbl_s[NCH-1:0] | gnt_dbl_s[2*NCH-1:NCH];
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating multiplexer with valid/ready handshakes, burst
// locking (a channel keeps the grant until its in_last beat) and a
// registered output stage.
module rr_arb_mux
  import rr_arb_pkg::*;
#(
  parameter  int NCH       = 2,
  parameter  int WIDTH     = 32,
  parameter  bit FIXED_PRI = 1'b0,
  localparam int IDW       = idw_of(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH-1:0]       in_last,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [IDW-1:0]       out_ch,
  output logic                 out_last,
  input  logic                 out_ready
);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   lock_ch_q, lock_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IDW-1:0]   out_ch_q, out_ch_d;
  logic             out_last_q, out_last_d;

  logic [NCH-1:0]   pick_grant_s;
  logic [IDW-1:0]   pick_idx_s;
  logic [NCH-1:0]   grant_s;
  logic [IDW-1:0]   sel_idx_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             sel_last_s;
  logic             load_s;
  logic             xfer_s;
  logic [NCH-1:0]   in_ready_s;

  rr_pick #(
    .NCH (NCH),
    .IDW (IDW)
  ) u_pick (
    .req        (in_valid),
    .start      (rr_ptr_q),
    .fixed_mode (FIXED_PRI),
    .grant      (pick_grant_s),
    .idx        (pick_idx_s)
  );

  // Grant selection, stage enable and the selected channel's beat.
  always_comb begin
    load_s = ~out_valid_q | out_ready;
    if (state_q == LOCK) begin
      grant_s   = NCH'(1'b1) << lock_ch_q;
      sel_idx_s = lock_ch_q;
    end else begin
      grant_s   = pick_grant_s;
      sel_idx_s = pick_idx_s;
    end
    // rst_n gating keeps every in_ready low while reset is asserted.
    in_ready_s = grant_s & in_valid & {NCH{load_s & rst_n}};
    xfer_s     = |in_ready_s;
    sel_data_s = in_data[sel_idx_s*WIDTH +: WIDTH];
    sel_last_s = in_last[sel_idx_s];
  end

  // Next-state for FSM, round-robin pointer, lock channel and output stage.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_ch_d   = lock_ch_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;

    if (xfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data_s;
      out_ch_d    = sel_idx_s;
      out_last_d  = sel_last_s;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      ARB: begin
        if (xfer_s && !sel_last_s) begin
          state_d   = LOCK;
          lock_ch_d = sel_idx_s;
        end else begin
          state_d = ARB;
        end
      end
      LOCK: begin
        if (xfer_s && sel_last_s) begin
          state_d = ARB;
        end else begin
          state_d = LOCK;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase

    if (!FIXED_PRI && xfer_s && sel_last_s) begin
      rr_ptr_d = (sel_idx_s == IDW'(NCH - 1)) ? {IDW{1'b0}} : sel_idx_s + 1'b1;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State and output registers; reset discards any in-flight beat or burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      rr_ptr_q    <= {IDW{1'b0}};
      lock_ch_q   <= {IDW{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
      out_ch_q    <= {IDW{1'b0}};
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_ch_q   <= lock_ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = (NCH == 1) ? {IDW{1'b0}} : out_ch_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench: a 3-channel round-robin instance and a 4-channel
// fixed-priority instance share clock and reset.
module tb_rr_arb_mux;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NCH=3, round-robin.
  logic [2:0]  a_valid, a_last, a_rdy;
  logic [23:0] a_data;
  logic        a_ov, a_ol, a_ordy;
  logic [7:0]  a_od;
  logic [1:0]  a_och;

  // Instance B: NCH=4, fixed priority.
  logic [3:0]  b_valid, b_last, b_rdy;
  logic [31:0] b_data;
  logic        b_ov, b_ol, b_ordy;
  logic [7:0]  b_od;
  logic [1:0]  b_och;

  rr_arb_mux #(.NCH(3), .WIDTH(8), .FIXED_PRI(1'b0)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_last(a_last),
    .in_data(a_data), .in_ready(a_rdy), .out_valid(a_ov), .out_data(a_od),
    .out_ch(a_och), .out_last(a_ol), .out_ready(a_ordy)
  );

  rr_arb_mux #(.NCH(4), .WIDTH(8), .FIXED_PRI(1'b1)) u_fp4 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_last(b_last),
    .in_data(b_data), .in_ready(b_rdy), .out_valid(b_ov), .out_data(b_od),
    .out_ch(b_och), .out_last(b_ol), .out_ready(b_ordy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] valid;
    logic [2:0] last;
    logic       ordy;
    logic [2:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_ch;
    logic       exp_ol;
  } vec_t;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_ch;
  } fvec_t;

  vec_t        vecs[23];
  fvec_t       fvecs[6];
  logic [7:0]  exp_data;

  initial begin
    // Round-robin over 3 channels, burst lock, idle lock, backpressure.
    vecs[0]  = '{3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 1'b1};
    vecs[1]  = '{3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 1'b1};
    vecs[2]  = '{3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 1'b1};
    vecs[3]  = '{3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 1'b1};
    vecs[4]  = '{3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 1'b1};
    vecs[5]  = '{3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 1'b1};
    vecs[6]  = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0, 1'b0};
    vecs[7]  = '{3'b011, 3'b000, 1'b1, 3'b001, 1'b1, 2'd0, 1'b0};
    vecs[8]  = '{3'b011, 3'b000, 1'b1, 3'b001, 1'b1, 2'd0, 1'b0};
    vecs[9]  = '{3'b011, 3'b000, 1'b1, 3'b001, 1'b1, 2'd0, 1'b0};
    vecs[10] = '{3'b011, 3'b001, 1'b1, 3'b001, 1'b1, 2'd0, 1'b1};
    vecs[11] = '{3'b010, 3'b010, 1'b1, 3'b010, 1'b1, 2'd1, 1'b1};
    vecs[12] = '{3'b100, 3'b000, 1'b1, 3'b100, 1'b1, 2'd2, 1'b0};
    vecs[13] = '{3'b011, 3'b011, 1'b1, 3'b000, 1'b0, 2'd0, 1'b0};
    vecs[14] = '{3'b101, 3'b100, 1'b1, 3'b100, 1'b1, 2'd2, 1'b1};
    vecs[15] = '{3'b010, 3'b010, 1'b0, 3'b000, 1'b1, 2'd2, 1'b1};
    vecs[16] = '{3'b010, 3'b010, 1'b0, 3'b000, 1'b1, 2'd2, 1'b1};
    vecs[17] = '{3'b010, 3'b010, 1'b0, 3'b000, 1'b1, 2'd2, 1'b1};
    vecs[18] = '{3'b010, 3'b010, 1'b1, 3'b010, 1'b1, 2'd1, 1'b1};
    vecs[19] = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0, 1'b0};
    vecs[20] = '{3'b001, 3'b001, 1'b0, 3'b001, 1'b1, 2'd0, 1'b1};
    vecs[21] = '{3'b001, 3'b001, 1'b0, 3'b000, 1'b1, 2'd0, 1'b1};
    vecs[22] = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0, 1'b0};

    // Fixed priority: channel 1 beats channel 3 whenever both request.
    fvecs[0] = '{4'b1010, 4'b0010, 1'b1, 2'd1};
    fvecs[1] = '{4'b1010, 4'b0010, 1'b1, 2'd1};
    fvecs[2] = '{4'b1010, 4'b0010, 1'b1, 2'd1};
    fvecs[3] = '{4'b1000, 4'b1000, 1'b1, 2'd3};
    fvecs[4] = '{4'b1010, 4'b0010, 1'b1, 2'd1};
    fvecs[5] = '{4'b0000, 4'b0000, 1'b0, 2'd0};

    a_valid = 3'b111; a_last = 3'b111; a_data = 24'h0; a_ordy = 1'b1;
    b_valid = 4'b1111; b_last = 4'b1111; b_data = 32'hB3B2B1B0; b_ordy = 1'b1;
    exp_data = 8'h00;

    // Reset held with every channel requesting.
    for (int r = 0; r < 3; r++) begin
      @(negedge clk); #1;
      chk("rst a_rdy", 32'(a_rdy), 32'h0);
      chk("rst a_ov", 32'(a_ov), 32'h0);
      chk("rst b_rdy", 32'(b_rdy), 32'h0);
      chk("rst b_ov", 32'(b_ov), 32'h0);
    end
    chk("rst a_od", 32'(a_od), 32'h0);
    chk("rst a_och", 32'(a_och), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    a_valid = 3'b000; b_valid = 4'b0000;

    // Table-driven run on the round-robin instance.
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      a_valid = vecs[i].valid;
      a_last  = vecs[i].last;
      a_ordy  = vecs[i].ordy;
      for (int c = 0; c < 3; c++) a_data[c*8 +: 8] = 8'(i*4 + c);
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(a_rdy), 32'(vecs[i].exp_rdy));
      if (vecs[i].exp_rdy != 3'b000) exp_data = 8'(i*4 + int'(vecs[i].exp_ch));
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), 32'(a_ov), 32'(vecs[i].exp_ov));
      if (vecs[i].exp_ov) begin
        chk($sformatf("v%0d out_ch", i), 32'(a_och), 32'(vecs[i].exp_ch));
        chk($sformatf("v%0d out_last", i), 32'(a_ol), 32'(vecs[i].exp_ol));
        chk($sformatf("v%0d out_data", i), 32'(a_od), 32'(exp_data));
      end
    end
    @(negedge clk);
    a_valid = 3'b000;

    // Fixed-priority instance.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b_valid = fvecs[i].valid;
      #1;
      chk($sformatf("f%0d in_ready", i), 32'(b_rdy), 32'(fvecs[i].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("f%0d out_valid", i), 32'(b_ov), 32'(fvecs[i].exp_ov));
      if (fvecs[i].exp_ov) begin
        chk($sformatf("f%0d out_ch", i), 32'(b_och), 32'(fvecs[i].exp_ch));
        chk($sformatf("f%0d out_data", i), 32'(b_od), 32'(8'hB0) + 32'(fvecs[i].exp_ch));
      end
    end

    // Reset in the middle of a ch0 burst after two beats.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a_valid = 3'b001; a_last = 3'b000; a_ordy = 1'b1;
      #1;
      chk($sformatf("mb%0d in_ready", k), 32'(a_rdy), 32'h1);
      @(posedge clk); #1;
      chk($sformatf("mb%0d out_ch", k), 32'(a_och), 32'h0);
    end
    chk("mb out_valid pre", 32'(a_ov), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mb out_valid in rst", 32'(a_ov), 32'h0);
    chk("mb in_ready in rst", 32'(a_rdy), 32'h0);
    @(negedge clk);
    a_valid = 3'b010; a_last = 3'b010;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post rst in_ready", 32'(a_rdy), 32'h2);
    @(posedge clk); #1;
    chk("post rst out_valid", 32'(a_ov), 32'h1);
    chk("post rst out_ch", 32'(a_och), 32'h1);
    @(negedge clk);
    a_valid = 3'b000;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
